// File: rtl/food_placer.sv
// rtl/food_placer.sv - samples RNG candidates, scans snake body RAM, commits a collision-free food position
module food_placer #(
    parameter int MAX_LEN   = 64,
    parameter int ADDR_W    = 6,
    parameter int X_MIN     = 3,
    parameter int X_MAX     = 157,
    parameter int Y_MIN     = 3,
    parameter int Y_MAX     = 117,
    parameter int MAX_TRIES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              place_req,
    input  logic [7:0]        rand_x,
    input  logic [6:0]        rand_y,
    input  logic [ADDR_W:0]   snake_len,
    output logic [ADDR_W-1:0] seg_addr,
    input  logic [7:0]        seg_x,
    input  logic [6:0]        seg_y,
    output logic [7:0]        food_x,
    output logic [6:0]        food_y,
    output logic              food_valid,
    output logic              busy,
    output logic              done,
    output logic              fail
);
    localparam int TRIES_W = $clog2(MAX_TRIES) + 1;

    localparam logic [7:0]         X_LO    = 8'(X_MIN);
    localparam logic [7:0]         X_HI    = 8'(X_MAX);
    localparam logic [6:0]         Y_LO    = 7'(Y_MIN);
    localparam logic [6:0]         Y_HI    = 7'(Y_MAX);
    localparam logic [TRIES_W-1:0] T_LIMIT = TRIES_W'(MAX_TRIES);
    localparam logic [ADDR_W:0]    L_MAX   = (ADDR_W+1)'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, SAMPLE, SCAN} state_t;

    state_t              state;
    logic [7:0]          cand_x;
    logic [6:0]          cand_y;
    logic [TRIES_W-1:0]  tries;
    logic                pipe_valid;
    logic [ADDR_W-1:0]   pipe_idx;

    logic [TRIES_W-1:0]  tries_inc;
    logic [ADDR_W:0]     eff_len;
    logic [ADDR_W:0]     last_idx;
    logic                in_range;
    logic                hit;
    logic                at_last;

    // Candidate qualification and scan-progress terms derived from the current state
    always_comb begin
        tries_inc = tries + 1'b1;
        // A length beyond the RAM depth is treated as a full-length snake
        eff_len   = (snake_len > L_MAX) ? L_MAX : snake_len;
        last_idx  = eff_len - 1'b1;
        in_range  = (rand_x >= X_LO) && (rand_x <= X_HI) &&
                    (rand_y >= Y_LO) && (rand_y <= Y_HI);
        hit       = pipe_valid && (seg_x == cand_x) && (seg_y == cand_y);
        at_last   = pipe_valid && ({1'b0, pipe_idx} == last_idx);
    end

    assign busy = (state != IDLE);

    // Request FSM: sample, scan body RAM, retry on collision, commit or give up
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cand_x     <= '0;
            cand_y     <= '0;
            tries      <= '0;
            seg_addr   <= '0;
            pipe_valid <= 1'b0;
            pipe_idx   <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (place_req) begin
                        food_valid <= 1'b0;
                        tries      <= '0;
                        state      <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    cand_x <= rand_x;
                    cand_y <= rand_y;
                    tries  <= tries_inc;
                    if (!in_range) begin
                        // Out-of-range draw counts as an attempt; give up once the budget is spent
                        if (tries_inc >= T_LIMIT) begin
                            done  <= 1'b1;
                            fail  <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (eff_len == '0) begin
                        food_x     <= rand_x;
                        food_y     <= rand_y;
                        food_valid <= 1'b1;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        seg_addr   <= '0;
                        pipe_valid <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    // Registered RAM: the data seen now belongs to the address issued last cycle
                    pipe_valid <= 1'b1;
                    pipe_idx   <= seg_addr;
                    if ({1'b0, seg_addr} < last_idx) begin
                        seg_addr <= seg_addr + 1'b1;
                    end
                    if (hit) begin
                        if (tries >= T_LIMIT) begin
                            done  <= 1'b1;
                            fail  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= SAMPLE;
                        end
                    end else if (at_last) begin
                        food_x     <= cand_x;
                        food_y     <= cand_y;
                        food_valid <= 1'b1;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_food_placer.sv
// tb/tb_food_placer.sv - directed self-checking bench for food_placer
module tb_food_placer;
    logic       clock = 1'b0;
    logic       reset;
    logic       place_req;
    logic [7:0] rand_x;
    logic [6:0] rand_y;
    logic [6:0] snake_len;
    logic [5:0] seg_addr;
    logic [7:0] seg_x;
    logic [6:0] seg_y;
    logic [7:0] food_x;
    logic [6:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       done;
    logic       fail;

    logic [7:0] mem_x [0:63];
    logic [6:0] mem_y [0:63];

    int checks = 0;
    int errors = 0;

    food_placer dut (
        .clock      (clock),
        .reset      (reset),
        .place_req  (place_req),
        .rand_x     (rand_x),
        .rand_y     (rand_y),
        .snake_len  (snake_len),
        .seg_addr   (seg_addr),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .done       (done),
        .fail       (fail)
    );

    always #5 clock = ~clock;

    // Registered body RAM model: data follows the address by one cycle
    always @(posedge clock) begin
        seg_x <= mem_x[seg_addr];
        seg_y <= mem_y[seg_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem_x[i] = 8'd1;
            mem_y[i] = 7'd1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        place_req = 1'b0;
        rand_x    = 8'd0;
        rand_y    = 7'd0;
        snake_len = 7'd0;
        clear_mem();
        tick();
        tick();
        chk("rst_food_x", food_x, 0);
        chk("rst_food_y", food_y, 0);
        chk("rst_valid", food_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_addr", seg_addr, 0);
        reset = 1'b0;
        tick();

        // 1: empty snake commits two edges after the request
        snake_len = 7'd0;
        rand_x = 8'd50; rand_y = 7'd40;
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        chk("t1_busy_e0", busy, 1);
        chk("t1_done_e0", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_fail", fail, 0);
        chk("t1_food_x", food_x, 50);
        chk("t1_food_y", food_y, 40);
        chk("t1_valid", food_valid, 1);
        chk("t1_busy", busy, 0);
        tick();
        chk("t1_done_pulse", done, 0);

        // 2: clean scan over four segments
        for (int i = 0; i < 4; i++) begin
            mem_x[i] = 8'(10 + i);
            mem_y[i] = 7'd10;
        end
        snake_len = 7'd4;
        rand_x = 8'd80; rand_y = 7'd60;
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        chk("t2_valid_cleared", food_valid, 0);
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("t2_addr_e%0d", e), seg_addr, (e <= 4) ? e - 1 : 3);
            chk($sformatf("t2_nodone_e%0d", e), done, 0);
        end
        tick();
        chk("t2_done", done, 1);
        chk("t2_fail", fail, 0);
        chk("t2_food_x", food_x, 80);
        chk("t2_food_y", food_y, 60);
        chk("t2_valid", food_valid, 1);

        // 3: collision at index 2, retry with a fresh sample
        mem_x[2] = 8'd80; mem_y[2] = 7'd60;
        rand_x = 8'd80; rand_y = 7'd60;
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        tick();
        rand_x = 8'd90; rand_y = 7'd70;
        for (int e = 2; e <= 10; e++) begin
            tick();
            chk($sformatf("t3_nodone_e%0d", e), done, 0);
        end
        tick();
        chk("t3_done", done, 1);
        chk("t3_fail", fail, 0);
        chk("t3_food_x", food_x, 90);
        chk("t3_food_y", food_y, 70);

        // 4: every candidate collides, sixteen attempts of three edges each
        clear_mem();
        mem_x[0] = 8'd5; mem_y[0] = 7'd5;
        snake_len = 7'd1;
        rand_x = 8'd5; rand_y = 7'd5;
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        for (int e = 1; e <= 47; e++) begin
            tick();
            chk($sformatf("t4_nodone_e%0d", e), done, 0);
        end
        tick();
        chk("t4_done", done, 1);
        chk("t4_fail", fail, 1);
        chk("t4_valid", food_valid, 0);
        chk("t4_busy", busy, 0);
        tick();
        chk("t4_fail_pulse", fail, 0);

        // 5: out-of-range draws are skipped; a request during scan is dropped
        mem_x[0] = 8'd10; mem_y[0] = 7'd10;
        rand_x = 8'd200; rand_y = 7'd3;
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        tick();
        chk("t5_busy_rej", busy, 1);
        tick();
        rand_x = 8'd20; rand_y = 7'd20;
        tick();
        chk("t5_addr_scan", seg_addr, 0);
        chk("t5_busy_scan", busy, 1);
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        chk("t5_nodone_e4", done, 0);
        tick();
        chk("t5_done", done, 1);
        chk("t5_food_x", food_x, 20);
        chk("t5_food_y", food_y, 20);
        tick();
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_done", done, 0);
        chk("t5_idle_valid", food_valid, 1);

        // 6: reset in the middle of a scan, then a normal request
        clear_mem();
        snake_len = 7'd8;
        rand_x = 8'd100; rand_y = 7'd100;
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_busy_pre", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_food_x", food_x, 0);
        chk("t6_food_y", food_y, 0);
        chk("t6_valid", food_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_fail", fail, 0);
        chk("t6_addr", seg_addr, 0);
        rand_x = 8'd30; rand_y = 7'd30;
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk($sformatf("t6_nodone_e%0d", e), done, 0);
        end
        tick();
        chk("t6_post_done", done, 1);
        chk("t6_post_fail", fail, 0);
        chk("t6_post_x", food_x, 30);
        chk("t6_post_y", food_y, 30);
        chk("t6_post_valid", food_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
